// File: rtl/regfile_2r2w.sv
`default_nettype none
//==============================================================================
// Module  : regfile_2r2w
// Desc    : Parametrised 2-read/2-write register file with a hardware clear
//           sequencer, register 0 hardwired to zero and write-collision flag.
//           Define REGFILE_BYPASS_EN for write-first reads (default read-first).
// Rev     : 1.0  initial release
//==============================================================================
module regfile_2r2w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYPASS_EN = 1'b1;
`else
    localparam bit c_BYPASS_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;
    logic              w_clear_last;
    logic              w_wa_ok;
    logic              w_wb_ok;
    logic              w_conflict;
    logic [DATA_W-1:0] w_ra_val;
    logic [DATA_W-1:0] w_rb_val;

    assign w_run        = (r_state == S_RUN);
    assign w_clear_last = (r_state == S_CLEAR) && (r_cnt == ADDR_W'(DEPTH - 1));
    assign w_wa_ok      = w_run && wa_en && (wa_addr != '0);
    assign w_wb_ok      = w_run && wb_en && (wb_addr != '0);
    assign w_conflict   = w_wa_ok && w_wb_ok && (wa_addr == wb_addr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_clear_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            ready   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) r_cnt <= r_cnt + ADDR_W'(1);
            if (w_clear_last) ready <= 1'b1;
        end
    end

    // Array has no reset; the clear sequencer zeroes it. Port B is written
    // last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wa_ok) r_mem[wa_addr] <= wa_data;
                if (w_wb_ok) r_mem[wb_addr] <= wb_data;
            end
        end
    end

    always_comb begin
        w_ra_val = r_mem[ra_addr];
        if (c_BYPASS_EN) begin
            if (w_wb_ok && (wb_addr == ra_addr))      w_ra_val = wb_data;
            else if (w_wa_ok && (wa_addr == ra_addr)) w_ra_val = wa_data;
        end
        if (ra_addr == '0) w_ra_val = '0;
    end

    always_comb begin
        w_rb_val = r_mem[rb_addr];
        if (c_BYPASS_EN) begin
            if (w_wb_ok && (wb_addr == rb_addr))      w_rb_val = wb_data;
            else if (w_wa_ok && (wa_addr == rb_addr)) w_rb_val = wa_data;
        end
        if (rb_addr == '0) w_rb_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            ra_data     <= '0;
            rb_data     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            ra_data     <= w_ra_val;
            rb_data     <= w_rb_val;
            wr_conflict <= w_conflict;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r2w.sv
`default_nettype none
//==============================================================================
// Module  : tb_regfile_2r2w
// Desc    : Directed self-checking bench for regfile_2r2w (default parameters).
// Rev     : 1.0  initial release
//==============================================================================
module tb_regfile_2r2w;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic       wa_en, wb_en;
    logic [4:0] wa_addr, wb_addr, ra_addr, rb_addr;
    logic [7:0] wa_data, wb_data;
    logic [7:0] ra_data, rb_data;
    logic       wr_conflict;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    regfile_2r2w #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_data     (ra_data),
        .rb_data     (rb_data),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; sample and drive 1 time unit afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_writes();
        wa_en = 1'b0; wb_en = 1'b0;
        wa_addr = '0; wb_addr = '0;
        wa_data = '0; wb_data = '0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_writes();
        ra_addr = '0; rb_addr = '0;

        // 1. Reset and clear
        repeat (3) tick();
        check("rst_ready", 8'(ready), 8'h00);
        check("rst_ra", ra_data, 8'h00);
        check("rst_rb", rb_data, 8'h00);
        check("rst_conflict", 8'(wr_conflict), 8'h00);
        rst = 1'b0;
        ra_addr = 5'd3; rb_addr = 5'd7;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check("clear_ready_low", 8'(ready), 8'h00);
        end
        check("clear_ra_zero", ra_data, 8'h00);
        tick();
        check("clear_ready_32", 8'(ready), 8'h01);
        for (int i = 0; i < 32; i++) begin
            ra_addr = 5'(i);
            rb_addr = 5'(31 - i);
            tick();
            check("clear_ra", ra_data, 8'h00);
            check("clear_rb", rb_data, 8'h00);
        end

        // 2. Basic write/read on both ports
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 8'hA5;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 8'h5A;
        tick();
        check("basic_no_conflict", 8'(wr_conflict), 8'h00);
        idle_writes();
        ra_addr = 5'd3; rb_addr = 5'd7;
        tick();
        check("basic_ra", ra_data, 8'hA5);
        check("basic_rb", rb_data, 8'h5A);

        // 3. Register 0: both ports writing addr 0 is discarded, no conflict
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 8'hFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 8'hEE;
        tick();
        check("r0_conflict", 8'(wr_conflict), 8'h00);
        idle_writes();
        ra_addr = 5'd0; rb_addr = 5'd0;
        tick();
        check("r0_ra", ra_data, 8'h00);
        check("r0_rb", rb_data, 8'h00);

        // 4. Collision: port B wins
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 8'h11;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 8'h22;
        tick();
        check("coll_flag", 8'(wr_conflict), 8'h01);
        idle_writes();
        ra_addr = 5'd9; rb_addr = 5'd9;
        tick();
        check("coll_flag_drop", 8'(wr_conflict), 8'h00);
        check("coll_ra", ra_data, 8'h22);
        check("coll_rb", rb_data, 8'h22);

        // 5. Read-during-write
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 8'h33;
        tick();
        wa_data = 8'h44;
        ra_addr = 5'd4; rb_addr = 5'd3;
        tick();
        check("rdw_ra", ra_data, c_BYPASS ? 8'h44 : 8'h33);
        check("rdw_rb_other", rb_data, 8'hA5);
        idle_writes();
        tick();
        check("rdw_ra_next", ra_data, 8'h44);
        // Bypass priority when both ports hit the read address
        wa_en = 1'b1; wa_addr = 5'd10; wa_data = 8'h55;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 8'h66;
        rb_addr = 5'd10;
        tick();
        check("rdw_coll_rb", rb_data, c_BYPASS ? 8'h66 : 8'h00);
        check("rdw_coll_flag", 8'(wr_conflict), 8'h01);
        idle_writes();
        tick();
        check("rdw_coll_rb_next", rb_data, 8'h66);

        // 6. Reset mid-operation
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 8'h77;
        tick();
        idle_writes();
        ra_addr = 5'd5;
        tick();
        check("mid_pre_ra", ra_data, 8'h77);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", 8'(ready), 8'h00);
        check("mid_rst_ra", ra_data, 8'h00);
        rst = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 8'h99;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 8'h99;
        repeat (10) tick();
        check("mid_clear_ready", 8'(ready), 8'h00);
        check("mid_clear_ra", ra_data, 8'h00);
        check("mid_clear_conflict", 8'(wr_conflict), 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check("mid_ready_latency", 8'(n), 8'd32);
        idle_writes();
        ra_addr = 5'd5; rb_addr = 5'd9;
        tick();
        check("mid_addr5_cleared", ra_data, 8'h00);
        check("mid_addr9_cleared", rb_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
